// File: rtl/eee_bbox_pkg.sv
// Shared types and constants for the red-object bounding-box detector.
// Coordinate width, Avalon-ST video packet type and the overlay colour live here.
package eee_bbox_pkg;

   localparam int                  COORD_W        = 11;
   localparam logic [COORD_W-1:0]  COORD_MAX      = '1;
   localparam logic [3:0]          PKT_TYPE_VIDEO = 4'h0;
   localparam logic [23:0]         OVERLAY_COLOUR = 24'h00FF00;

   typedef enum logic [1:0] {
      IDLE,
      VIDEO,
      CTRL
   } state_t;

endpackage

// File: rtl/eee_bbox_accum.sv
// Colour match test and min/max accumulation of matching pixel coordinates.
// The *_nxt outputs expose the post-update values so an EOP pixel is included in the latched box.
module eee_bbox_accum
   import eee_bbox_pkg::*;
#(
   parameter logic [7:0] R_MIN  = 8'd180,
   parameter logic [7:0] GB_MAX = 8'd80
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               pix_en,
   input  logic [COORD_W-1:0] pix_x,
   input  logic [COORD_W-1:0] pix_y,
   input  logic [23:0]        pix_data,
   output logic [COORD_W-1:0] left_nxt,
   output logic [COORD_W-1:0] right_nxt,
   output logic [COORD_W-1:0] top_nxt,
   output logic [COORD_W-1:0] bottom_nxt,
   output logic               found_nxt
);

   logic [COORD_W-1:0] acc_left, acc_right, acc_top, acc_bottom;
   logic               acc_found;

   function automatic logic is_match(input logic [23:0] d);
      return (d[23:16] >= R_MIN) && (d[15:8] <= GB_MAX) && (d[7:0] <= GB_MAX);
   endfunction

   always_comb begin
      left_nxt   = acc_left;
      right_nxt  = acc_right;
      top_nxt    = acc_top;
      bottom_nxt = acc_bottom;
      found_nxt  = acc_found;
      if (clear) begin
         left_nxt   = COORD_MAX;
         right_nxt  = '0;
         top_nxt    = COORD_MAX;
         bottom_nxt = '0;
         found_nxt  = 1'b0;
      end else if (pix_en && is_match(pix_data)) begin
         left_nxt   = (pix_x < acc_left)   ? pix_x : acc_left;
         right_nxt  = (pix_x > acc_right)  ? pix_x : acc_right;
         top_nxt    = (pix_y < acc_top)    ? pix_y : acc_top;
         bottom_nxt = (pix_y > acc_bottom) ? pix_y : acc_bottom;
         found_nxt  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_left   <= COORD_MAX;
         acc_right  <= '0;
         acc_top    <= COORD_MAX;
         acc_bottom <= '0;
         acc_found  <= 1'b0;
      end else begin
         acc_left   <= left_nxt;
         acc_right  <= right_nxt;
         acc_top    <= top_nxt;
         acc_bottom <= bottom_nxt;
         acc_found  <= found_nxt;
      end
   end

endmodule

// File: rtl/eee_bbox_detect.sv
// Avalon-ST video pass-through that reports the bounding box of red pixels per frame.
// Define EEE_BBOX_OVERLAY_EN to draw the previous frame's box in green when mode=1.
module eee_bbox_detect
   import eee_bbox_pkg::*;
#(
   parameter int         IMG_WIDTH  = 640,
   parameter int         IMG_HEIGHT = 480,
   parameter logic [7:0] R_MIN      = 8'd180,
   parameter logic [7:0] GB_MAX     = 8'd80
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [23:0]        sink_data,
   input  logic               sink_valid,
   input  logic               sink_startofpacket,
   input  logic               sink_endofpacket,
   output logic               sink_ready,
   output logic [23:0]        source_data,
   output logic               source_valid,
   output logic               source_startofpacket,
   output logic               source_endofpacket,
   input  logic               source_ready,
   input  logic               mode,
   output logic [COORD_W-1:0] bbox_left,
   output logic [COORD_W-1:0] bbox_right,
   output logic [COORD_W-1:0] bbox_top,
   output logic [COORD_W-1:0] bbox_bottom,
   output logic               bbox_found,
   output logic               bbox_strobe
);

   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_END  = COORD_W'(IMG_HEIGHT);

   state_t             state;
   logic [COORD_W-1:0] x_cnt, y_cnt;
   logic               vld_p1, sop_p1, eop_p1;
   logic [23:0]        data_p1;
   logic               in_xfer, hdr_video, vid_sop, pix_beat, pix_en, vid_eop;
   logic [23:0]        pix_out;
   logic [COORD_W-1:0] acc_left, acc_right, acc_top, acc_bottom;
   logic               acc_found;

   assign sink_ready           = ~vld_p1 | source_ready;
   assign source_valid         = vld_p1;
   assign source_startofpacket = sop_p1;
   assign source_endofpacket   = eop_p1;
   assign source_data          = data_p1;

   assign in_xfer   = sink_valid & sink_ready;
   assign hdr_video = (sink_data[3:0] == PKT_TYPE_VIDEO);
   assign vid_sop   = in_xfer & sink_startofpacket & hdr_video;
   assign pix_beat  = in_xfer & ~sink_startofpacket & (state == VIDEO);
   assign pix_en    = pix_beat & (y_cnt < Y_END);
   // A video SOP that is also EOP latches the freshly cleared (empty) accumulators.
   assign vid_eop   = in_xfer & sink_endofpacket &
                      (sink_startofpacket ? hdr_video : (state == VIDEO));

`ifdef EEE_BBOX_OVERLAY_EN
   function automatic logic on_perimeter(input logic [COORD_W-1:0] x, y, l, r, t, b);
      return (((x == l) || (x == r)) && (y >= t) && (y <= b)) ||
             (((y == t) || (y == b)) && (x >= l) && (x <= r));
   endfunction

   assign pix_out = (pix_beat && mode && bbox_found &&
                     on_perimeter(x_cnt, y_cnt, bbox_left, bbox_right, bbox_top, bbox_bottom))
                    ? OVERLAY_COLOUR : sink_data;
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign pix_out     = sink_data;
`endif

   eee_bbox_accum #(
      .R_MIN  (R_MIN),
      .GB_MAX (GB_MAX)
   ) u_accum (
      .clk        (clk),
      .reset      (reset),
      .clear      (vid_sop),
      .pix_en     (pix_en),
      .pix_x      (x_cnt),
      .pix_y      (y_cnt),
      .pix_data   (sink_data),
      .left_nxt   (acc_left),
      .right_nxt  (acc_right),
      .top_nxt    (acc_top),
      .bottom_nxt (acc_bottom),
      .found_nxt  (acc_found)
   );

   // Stage p1: single output register toward the source interface
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1  <= 1'b0;
         sop_p1  <= 1'b0;
         eop_p1  <= 1'b0;
         data_p1 <= '0;
      end else if (in_xfer) begin
         vld_p1  <= 1'b1;
         sop_p1  <= sink_startofpacket;
         eop_p1  <= sink_endofpacket;
         data_p1 <= pix_out;
      end else if (source_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         x_cnt       <= '0;
         y_cnt       <= '0;
         bbox_left   <= '0;
         bbox_right  <= '0;
         bbox_top    <= '0;
         bbox_bottom <= '0;
         bbox_found  <= 1'b0;
         bbox_strobe <= 1'b0;
      end else begin
         bbox_strobe <= 1'b0;
         if (in_xfer) begin
            if (sink_startofpacket) begin
               state <= sink_endofpacket ? IDLE : (hdr_video ? VIDEO : CTRL);
               if (hdr_video) begin
                  x_cnt <= '0;
                  y_cnt <= '0;
               end
            end else if (sink_endofpacket) begin
               state <= IDLE;
            end
            // Counters stop once y reaches IMG_HEIGHT; surplus pixels are only forwarded.
            if (pix_en) begin
               if (x_cnt == X_LAST) begin
                  x_cnt <= '0;
                  y_cnt <= y_cnt + 1'b1;
               end else begin
                  x_cnt <= x_cnt + 1'b1;
               end
            end
            if (vid_eop) begin
               bbox_left   <= acc_left;
               bbox_right  <= acc_right;
               bbox_top    <= acc_top;
               bbox_bottom <= acc_bottom;
               bbox_found  <= acc_found;
               bbox_strobe <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_eee_bbox_detect.sv
// Randomised self-checking bench for eee_bbox_detect on an 8x4 frame geometry.
// Expected stream and box results come from a packet-level reference model.
module tb_eee_bbox_detect;

   localparam int W = 8;
   localparam int H = 4;
`ifdef EEE_BBOX_OVERLAY_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic [23:0] data;
   } beat_t;

   typedef struct packed {
      logic        found;
      logic [10:0] l;
      logic [10:0] r;
      logic [10:0] t;
      logic [10:0] b;
   } box_t;

   logic        clk, reset;
   logic [23:0] sink_data;
   logic        sink_valid, sink_startofpacket, sink_endofpacket, sink_ready;
   logic [23:0] source_data;
   logic        source_valid, source_startofpacket, source_endofpacket, source_ready;
   logic        mode;
   logic [10:0] bbox_left, bbox_right, bbox_top, bbox_bottom;
   logic        bbox_found, bbox_strobe;

   int    n_checks = 0;
   int    n_err    = 0;
   int    hold_viol = 0;
   int    hold_seen = 0;
   bit    bp_en  = 1'b0;
   bit    gap_en = 1'b0;
   box_t  prev_box;
   beat_t pkt[$];
   beat_t obs_q[$], exp_q[$];
   box_t  obs_box_q[$], exp_box_q[$];

   eee_bbox_detect #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .sink_data            (sink_data),
      .sink_valid           (sink_valid),
      .sink_startofpacket   (sink_startofpacket),
      .sink_endofpacket     (sink_endofpacket),
      .sink_ready           (sink_ready),
      .source_data          (source_data),
      .source_valid         (source_valid),
      .source_startofpacket (source_startofpacket),
      .source_endofpacket   (source_endofpacket),
      .source_ready         (source_ready),
      .mode                 (mode),
      .bbox_left            (bbox_left),
      .bbox_right           (bbox_right),
      .bbox_top             (bbox_top),
      .bbox_bottom          (bbox_bottom),
      .bbox_found           (bbox_found),
      .bbox_strobe          (bbox_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   function automatic box_t cur_box();
      return '{found: bbox_found, l: bbox_left, r: bbox_right, t: bbox_top, b: bbox_bottom};
   endfunction

   // Downstream backpressure
   initial begin
      source_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         source_ready = bp_en ? ($urandom % 2 == 1) : 1'b1;
      end
   end

   // Output monitor: collects transfers and strobes, checks hold stability
   initial begin
      beat_t last, cur;
      logic  held;
      held = 1'b0;
      last = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            held = 1'b0;
         end else begin
            cur = '{sop: source_startofpacket, eop: source_endofpacket, data: source_data};
            if (held) begin
               hold_seen++;
               if (!source_valid || cur !== last) hold_viol++;
            end
            held = source_valid & ~source_ready;
            last = cur;
            if (source_valid && source_ready) obs_q.push_back(cur);
            if (bbox_strobe) obs_box_q.push_back(cur_box());
         end
      end
   end

   function automatic bit is_red(input logic [23:0] d);
      return (d[23:16] >= 8'd180) && (d[15:8] <= 8'd80) && (d[7:0] <= 8'd80);
   endfunction

   function automatic bit on_box(input int x, input int y, input box_t b);
      return ((x == b.l || x == b.r) && y >= b.t && y <= b.b) ||
             ((y == b.t || y == b.b) && x >= b.l && x <= b.r);
   endfunction

   // Reference model: whole-packet view using raster index -> (x, y)
   task automatic model_pkt();
      box_t cur;
      if (pkt[0].data[3:0] != 4'h0) begin
         foreach (pkt[i]) exp_q.push_back(pkt[i]);
      end else begin
         cur = '{found: 1'b0, l: 11'd2047, r: 11'd0, t: 11'd2047, b: 11'd0};
         exp_q.push_back(pkt[0]);
         for (int i = 1; i < pkt.size(); i++) begin
            int    idx = i - 1;
            int    x   = idx % W;
            int    y   = idx / W;
            beat_t b   = pkt[i];
            if (idx < W * H) begin
               if (OVL && mode && prev_box.found && on_box(x, y, prev_box))
                  b.data = 24'h00FF00;
               if (is_red(pkt[i].data)) begin
                  cur.found = 1'b1;
                  if (x < cur.l) cur.l = 11'(x);
                  if (x > cur.r) cur.r = 11'(x);
                  if (y < cur.t) cur.t = 11'(y);
                  if (y > cur.b) cur.b = 11'(y);
               end
            end
            exp_q.push_back(b);
         end
         if (pkt[pkt.size()-1].eop) begin
            exp_box_q.push_back(cur);
            prev_box = cur;
         end
      end
   endtask

   task automatic send_beat(input beat_t bt);
      int n;
      if (gap_en && ($urandom % 4 == 0)) begin
         @(posedge clk);
         #1;
      end
      sink_data          = bt.data;
      sink_startofpacket = bt.sop;
      sink_endofpacket   = bt.eop;
      sink_valid         = 1'b1;
      n = 0;
      @(negedge clk);
      while (!sink_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) chk("sink_ready_timeout", 1, 0);
      @(posedge clk);
      #1;
      sink_valid = 1'b0;
      if (!bp_en) chk("latency_valid",
                      {source_valid, source_startofpacket, source_endofpacket},
                      {1'b1, bt.sop, bt.eop});
   endtask

   task automatic start_pkt(input logic [23:0] hdr);
      pkt.delete();
      pkt.push_back('{sop: 1'b1, eop: 1'b0, data: hdr});
   endtask

   task automatic add_beat(input logic [23:0] d);
      pkt.push_back('{sop: 1'b0, eop: 1'b0, data: d});
   endtask

   task automatic close_pkt();
      pkt[pkt.size()-1].eop = 1'b1;
   endtask

   task automatic send_pkt();
      model_pkt();
      foreach (pkt[i]) send_beat(pkt[i]);
   endtask

   function automatic logic [23:0] rand_pix();
      if ($urandom % 5 == 0)
         return {8'($urandom_range(170, 255)), 8'($urandom_range(0, 90)), 8'($urandom_range(0, 90))};
      return 24'($urandom);
   endfunction

   task automatic drain();
      int n = 0;
      while ((obs_q.size() < exp_q.size() || source_valid) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) chk("drain_timeout", 1, 0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic compare(input string tag);
      int nb;
      chk($sformatf("%s_beats", tag), obs_q.size(), exp_q.size());
      nb = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < nb; i++) chk($sformatf("%s_beat%0d", tag, i), obs_q[i], exp_q[i]);
      chk($sformatf("%s_strobes", tag), obs_box_q.size(), exp_box_q.size());
      nb = (obs_box_q.size() < exp_box_q.size()) ? obs_box_q.size() : exp_box_q.size();
      for (int i = 0; i < nb; i++) chk($sformatf("%s_box%0d", tag, i), obs_box_q[i], exp_box_q[i]);
      obs_q.delete();
      exp_q.delete();
      obs_box_q.delete();
      exp_box_q.delete();
   endtask

   initial begin
      reset = 1'b1;
      sink_data = '0;
      sink_valid = 1'b0;
      sink_startofpacket = 1'b0;
      sink_endofpacket = 1'b0;
      mode = 1'b0;
      prev_box = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", source_valid, 0);
      chk("rst_sop_eop", {source_startofpacket, source_endofpacket}, 0);
      chk("rst_data", source_data, 0);
      chk("rst_box", cur_box(), 0);
      chk("rst_strobe", bbox_strobe, 0);
      chk("rst_sink_ready", sink_ready, 1);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Two red pixels at (2,1) and (5,3)
      start_pkt(24'h000000);
      for (int i = 0; i < W * H; i++) add_beat((i == 1*W + 2 || i == 3*W + 5) ? 24'hFF0000 : 24'h0);
      close_pkt();
      send_pkt();
      drain();
      chk("frameA_box", cur_box(), {1'b1, 11'd2, 11'd5, 11'd1, 11'd3});
      chk("frameA_one_strobe", obs_box_q.size(), 1);
      compare("frameA");

      // Control packet with red payload
      start_pkt(24'h00000F);
      repeat (3) add_beat(24'hFF0000);
      close_pkt();
      send_pkt();
      drain();
      chk("ctrl_no_strobe", obs_box_q.size(), 0);
      chk("ctrl_box_kept", cur_box(), {1'b1, 11'd2, 11'd5, 11'd1, 11'd3});
      compare("ctrl");

      // Overlay of the previous box with mode=1
      mode = 1'b1;
      start_pkt(24'h000000);
      repeat (W * H) add_beat(24'h123456);
      close_pkt();
      send_pkt();
      drain();
      chk("ovl_pix_3_1", obs_q[1 + 1*W + 3].data, OVL ? 24'h00FF00 : 24'h123456);
      chk("ovl_pix_3_2", obs_q[1 + 2*W + 3].data, 24'h123456);
      compare("overlay");
      mode = 1'b0;

      // Threshold boundaries: only (1,0) qualifies
      start_pkt(24'h000000);
      for (int i = 0; i < W * H; i++)
         add_beat(i == 1       ? 24'hB45050 :
                  i == 2*W + 6 ? 24'hB35050 :
                  i == 3*W + 7 ? 24'hB45150 :
                  i == 3*W     ? 24'hB45051 : 24'h0);
      close_pkt();
      send_pkt();
      drain();
      chk("thresh_box", cur_box(), {1'b1, 11'd1, 11'd1, 11'd0, 11'd0});
      compare("thresh");

      // All-black frame
      start_pkt(24'h000000);
      repeat (W * H) add_beat(24'h0);
      close_pkt();
      send_pkt();
      drain();
      chk("black_found", bbox_found, 0);
      chk("black_one_strobe", obs_box_q.size(), 1);
      compare("black");

      // Video SOP that is also EOP
      start_pkt(24'h000000);
      close_pkt();
      send_pkt();
      drain();
      compare("sop_eop");

      // Random packet mix under backpressure and sink gaps
      bp_en  = 1'b1;
      gap_en = 1'b1;
      for (int p = 0; p < 60; p++) begin
         int k = $urandom % 8;
         int n;
         mode = $urandom % 2;
         if (k == 0) begin
            start_pkt({20'($urandom), 4'($urandom_range(1, 15))});
            n = $urandom_range(0, 5);
         end else begin
            start_pkt({20'($urandom), 4'h0});
            n = (k == 1) ? $urandom_range(1, 20) :
                (k == 2) ? $urandom_range(1, W * H - 1) :
                (k == 3) ? W * H + $urandom_range(1, 12) :
                (k == 4) ? 0 : W * H;
         end
         repeat (n) add_beat(rand_pix());
         if (k != 1 || p == 59) close_pkt();
         send_pkt();
      end
      drain();
      compare("random");
      chk("hold_exercised", hold_seen > 0, 1);
      bp_en  = 1'b0;
      gap_en = 1'b0;
      mode   = 1'b0;

      // Reset in the middle of a frame, then a clean frame
      start_pkt(24'h000000);
      for (int i = 0; i < W * H; i++) add_beat(i == 4 ? 24'hFF0000 : 24'h0);
      close_pkt();
      for (int i = 0; i < 15; i++) send_beat(pkt[i]);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_valid", source_valid, 0);
      chk("midrst_box", cur_box(), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      prev_box = '0;
      obs_q.delete();
      exp_q.delete();
      obs_box_q.delete();
      exp_box_q.delete();
      @(posedge clk);
      #1;
      start_pkt(24'h000000);
      for (int i = 0; i < W * H; i++) add_beat((i == 2*W + 6 || i == 1*W + 1) ? 24'hFF2020 : 24'h0);
      close_pkt();
      send_pkt();
      drain();
      chk("midrst_after_box", cur_box(), {1'b1, 11'd1, 11'd6, 11'd1, 11'd2});
      compare("midrst");

      chk("hold_stable", hold_viol, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
